// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

   // Memory port geometry: 4 lane-groups, 7-bit transaction tag.
   localparam int LANE_GRPS   = 4;
   localparam int TAG_W       = 7;

   // Default flattened bus widths: 64 lanes x 32b addresses, 64 lanes x 128b data.
   localparam int DEF_ADDR_W  = 2048;
   localparam int DEF_DATA_W  = 8192;

   // Watchdog counter width and default limit.
   localparam int WD_W        = 8;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   // Walk the requesters starting at ptr and stop at the first valid one.
   always_comb begin
      logic [IDX_W-1:0] idx;
      logic             found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
         idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one gm/LDS memory port among NUM_REQ requesters, one transaction in flight.
// Latency: accept at 0, issue at 1, ack at k>=2, response pulse at k+1; watchdog bounds the wait.
// Backpressure: req_ready only in IDLE (round-robin one-hot); responses are single-cycle pulses with no stall.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_gm_or_lds,
   input  logic [NUM_REQ*LANE_GRPS-1:0] req_rd_en,
   input  logic [NUM_REQ*LANE_GRPS-1:0] req_wr_en,
   input  logic [NUM_REQ*ADDR_W-1:0]    req_addresses,
   input  logic [NUM_REQ*DATA_W-1:0]    req_wr_data,
   input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic                         resp_err,
   output logic [TAG_W-1:0]             resp_tag,
   output logic [DATA_W-1:0]            resp_rd_data,
   output logic                         mem_gm_or_lds,
   output logic [LANE_GRPS-1:0]         mem_rd_en,
   output logic [LANE_GRPS-1:0]         mem_wr_en,
   output logic [ADDR_W-1:0]            mem_addresses,
   output logic [DATA_W-1:0]            mem_wr_data,
   output logic [TAG_W-1:0]             mem_input_tag,
   input  logic                         mem_ack,
   input  logic [TAG_W-1:0]             mem_output_tag,
   input  logic [DATA_W-1:0]            mem_rd_data,
   output logic                         err_spurious
);

   localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);

   arb_state_e             state;
   arb_state_e             state_nxt;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       owner;
   logic [NUM_REQ-1:0]     owner_oh;
   logic [NUM_REQ-1:0]     gnt;
   logic [IDX_W-1:0]       gnt_idx;
   logic [WD_W-1:0]        wd_cnt;
   logic                   accept;
   logic                   ack_match;
   logic                   wd_expired;
   logic                   sel_no_access;

   // Per-requester views of the flattened request buses, indexed by grant.
   logic                   gm_a   [NUM_REQ];
   logic [LANE_GRPS-1:0]   rd_a   [NUM_REQ];
   logic [LANE_GRPS-1:0]   wr_a   [NUM_REQ];
   logic [ADDR_W-1:0]      addr_a [NUM_REQ];
   logic [DATA_W-1:0]      data_a [NUM_REQ];
   logic [TAG_W-1:0]       tag_a  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
      assign gm_a[g]   = req_gm_or_lds[g];
      assign rd_a[g]   = req_rd_en[g*LANE_GRPS +: LANE_GRPS];
      assign wr_a[g]   = req_wr_en[g*LANE_GRPS +: LANE_GRPS];
      assign addr_a[g] = req_addresses[g*ADDR_W +: ADDR_W];
      assign data_a[g] = req_wr_data[g*DATA_W +: DATA_W];
      assign tag_a[g]  = req_tag[g*TAG_W +: TAG_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Grants are only offered while idle; elsewhere the port is busy.
   assign req_ready     = (state == ST_IDLE) ? gnt : '0;
   assign sel_no_access = ~|(rd_a[gnt_idx] | wr_a[gnt_idx]);
   assign owner_oh      = NUM_REQ'(1) << owner;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode plus the per-cycle events the datapath acts on.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      ack_match  = 1'b0;
      wd_expired = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|gnt) begin
               accept    = 1'b1;
               // A request with no lane enables never touches memory.
               state_nxt = sel_no_access ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (mem_ack && (mem_output_tag == mem_input_tag)) begin
               ack_match = 1'b1;
               state_nxt = ST_RESP;
            end else if (wd_cnt == WD_LIMIT) begin
               wd_expired = 1'b1;
               state_nxt  = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, memory-side outputs, watchdog and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr        <= '0;
         owner         <= '0;
         wd_cnt        <= '0;
         mem_gm_or_lds <= 1'b0;
         mem_rd_en     <= '0;
         mem_wr_en     <= '0;
         mem_addresses <= '0;
         mem_wr_data   <= '0;
         mem_input_tag <= '0;
         resp_valid    <= '0;
         resp_err      <= 1'b0;
         resp_tag      <= '0;
         resp_rd_data  <= '0;
         err_spurious  <= 1'b0;
      end else begin
         resp_valid   <= '0;
         // Any ack that does not complete the in-flight request is flagged.
         err_spurious <= mem_ack & ~ack_match;

         if (accept) begin
            owner         <= gnt_idx;
            rr_ptr        <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            mem_gm_or_lds <= gm_a[gnt_idx];
            mem_rd_en     <= rd_a[gnt_idx];
            mem_wr_en     <= wr_a[gnt_idx];
            mem_addresses <= addr_a[gnt_idx];
            mem_wr_data   <= data_a[gnt_idx];
            mem_input_tag <= tag_a[gnt_idx];
            if (sel_no_access) begin
               resp_valid   <= gnt;
               resp_err     <= 1'b0;
               resp_tag     <= tag_a[gnt_idx];
               resp_rd_data <= '0;
            end
         end

         if (state == ST_ISSUE) begin
            mem_rd_en <= '0;
            mem_wr_en <= '0;
            wd_cnt    <= '0;
         end

         if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (ack_match) begin
               resp_valid   <= owner_oh;
               resp_err     <= 1'b0;
               resp_tag     <= mem_output_tag;
               resp_rd_data <= mem_rd_data;
            end else if (wd_expired) begin
               resp_valid   <= owner_oh;
               resp_err     <= 1'b1;
               resp_tag     <= mem_input_tag;
               resp_rd_data <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a tiny group-granular memory store.
// Latency: checks issue, ack-to-response and watchdog timing cycle by cycle.
// Backpressure: drives contention, spurious acks and a mid-transaction reset.
module tb_mem_port_arbiter;

   localparam int NR   = 2;
   localparam int AW   = 2048;
   localparam int DW   = 8192;
   localparam int TO   = 255;
   localparam int GW_A = AW / 4;
   localparam int GW_D = DW / 4;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_gm_or_lds;
   logic [NR*4-1:0]   req_rd_en;
   logic [NR*4-1:0]   req_wr_en;
   logic [NR*AW-1:0]  req_addresses;
   logic [NR*DW-1:0]  req_wr_data;
   logic [NR*7-1:0]   req_tag;
   logic [NR-1:0]     resp_valid;
   logic              resp_err;
   logic [6:0]        resp_tag;
   logic [DW-1:0]     resp_rd_data;
   logic              mem_gm_or_lds;
   logic [3:0]        mem_rd_en;
   logic [3:0]        mem_wr_en;
   logic [AW-1:0]     mem_addresses;
   logic [DW-1:0]     mem_wr_data;
   logic [6:0]        mem_input_tag;
   logic              mem_ack;
   logic [6:0]        mem_output_tag;
   logic [DW-1:0]     mem_rd_data;
   logic              err_spurious;

   int n_checks = 0;
   int n_errors = 0;

   logic [GW_D-1:0] store [logic [31:0]];

   mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_gm_or_lds  (req_gm_or_lds),
      .req_rd_en      (req_rd_en),
      .req_wr_en      (req_wr_en),
      .req_addresses  (req_addresses),
      .req_wr_data    (req_wr_data),
      .req_tag        (req_tag),
      .resp_valid     (resp_valid),
      .resp_err       (resp_err),
      .resp_tag       (resp_tag),
      .resp_rd_data   (resp_rd_data),
      .mem_gm_or_lds  (mem_gm_or_lds),
      .mem_rd_en      (mem_rd_en),
      .mem_wr_en      (mem_wr_en),
      .mem_addresses  (mem_addresses),
      .mem_wr_data    (mem_wr_data),
      .mem_input_tag  (mem_input_tag),
      .mem_ack        (mem_ack),
      .mem_output_tag (mem_output_tag),
      .mem_rd_data    (mem_rd_data),
      .err_spurious   (err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete within time limit");
      $fatal(1, "bench time limit");
   end

   // Lane-group g carries its address in lane 16*g: base, base+0x10, ...
   function automatic logic [AW-1:0] mk_addr(input logic [31:0] base);
      logic [AW-1:0] a;
      a = '0;
      for (int g = 0; g < 4; g++) a[g*GW_A +: 32] = base + 32'(g * 16);
      return a;
   endfunction

   function automatic logic [DW-1:0] mk_data(input logic [31:0] seed);
      logic [DW-1:0] d;
      for (int l = 0; l < 64; l++)
         d[l*128 +: 128] = {seed, 32'(l), ~seed, 32'hC0DE_0000 | 32'(l)};
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic gm, input logic [3:0] rd, input logic [3:0] wr,
                          input logic [6:0] tag, input logic [31:0] abase, input logic [31:0] seed);
      req_gm_or_lds[r]          = gm;
      req_rd_en[r*4 +: 4]       = rd;
      req_wr_en[r*4 +: 4]       = wr;
      req_tag[r*7 +: 7]         = tag;
      req_addresses[r*AW +: AW] = mk_addr(abase);
      req_wr_data[r*DW +: DW]   = mk_data(seed);
   endtask

   // Memory model: store enabled lane-groups during ISSUE.
   task automatic capture_write();
      for (int g = 0; g < 4; g++)
         if (mem_wr_en[g]) store[mem_addresses[g*GW_A +: 32]] = mem_wr_data[g*GW_D +: GW_D];
   endtask

   task automatic build_read(output logic [DW-1:0] rd);
      rd = '0;
      for (int g = 0; g < 4; g++)
         if (mem_rd_en[g] && store.exists(mem_addresses[g*GW_A +: 32]))
            rd[g*GW_D +: GW_D] = store[mem_addresses[g*GW_A +: 32]];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0;
      repeat (3) tick();
      n_checks++; if (resp_valid !== 2'b00) begin n_errors++; $display("FAIL rst_resp_valid: got %b exp 00", resp_valid); end
      n_checks++; if (err_spurious !== 1'b0) begin n_errors++; $display("FAIL rst_err_spurious: got %b exp 0", err_spurious); end
      n_checks++; if ({mem_rd_en, mem_wr_en} !== 8'h00) begin n_errors++; $display("FAIL rst_mem_en: got %h exp 00", {mem_rd_en, mem_wr_en}); end
      n_checks++; if (mem_input_tag !== 7'd0) begin n_errors++; $display("FAIL rst_mem_tag: got %0d exp 0", mem_input_tag); end
      n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL rst_req_ready: got %b exp 00", req_ready); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      set_req(0, 1'b1, 4'b0001, 4'b0000, 7'd10, 32'h100, 32'h22);
      set_req(1, 1'b0, 4'b0000, 4'b0010, 7'd11, 32'h200, 32'h33);
      req_valid = 2'b11;
      for (int t = 0; t < 6; t++) begin
         int         w;
         logic [1:0] exp_oh;
         exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         w = 0;
         while (req_ready == 2'b00 && w < 300) begin tick(); w++; end
         n_checks++; if (req_ready !== exp_oh) begin n_errors++; $display("FAIL rr_grant%0d: got %b exp %b", t, req_ready, exp_oh); end
         tick();
         if (t == 0) begin
            n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL rr_ready_busy: got %b exp 00", req_ready); end
         end
         tick();
         mem_ack = 1'b1;
         mem_output_tag = (t % 2 == 0) ? 7'd10 : 7'd11;
         tick();
         mem_ack = 1'b0;
         n_checks++; if (resp_valid !== exp_oh) begin n_errors++; $display("FAIL rr_resp%0d: got %b exp %b", t, resp_valid, exp_oh); end
         tick();
      end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic test_write();
      logic [DW-1:0] wd;
      wd = mk_data(32'h1111_1111);
      set_req(0, 1'b1, 4'b0000, 4'b0101, 7'd1, 32'h04, 32'h1111_1111);
      req_valid = 2'b01;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL wr_grant: got %b exp 01", req_ready); end
      tick();
      n_checks++; if (mem_wr_en !== 4'b0101 || mem_rd_en !== 4'b0000) begin n_errors++; $display("FAIL wr_issue_en: got wr %b rd %b exp wr 0101 rd 0000", mem_wr_en, mem_rd_en); end
      n_checks++; if (mem_input_tag !== 7'd1 || mem_gm_or_lds !== 1'b1) begin n_errors++; $display("FAIL wr_issue_tag: got tag %0d gm %b exp 1 1", mem_input_tag, mem_gm_or_lds); end
      n_checks++; if (mem_addresses[0 +: 32] !== 32'h04 || mem_addresses[2*GW_A +: 32] !== 32'h24) begin n_errors++; $display("FAIL wr_issue_addr: got %h %h exp 04 24", mem_addresses[0 +: 32], mem_addresses[2*GW_A +: 32]); end
      n_checks++; if (mem_wr_data[127:0] !== wd[127:0]) begin n_errors++; $display("FAIL wr_issue_data: got %h exp %h", mem_wr_data[127:0], wd[127:0]); end
      capture_write();
      req_valid = 2'b00;
      tick();
      n_checks++; if (mem_wr_en !== 4'b0000) begin n_errors++; $display("FAIL wr_en_one_cycle: got %b exp 0000", mem_wr_en); end
      tick();
      mem_ack = 1'b1;
      mem_output_tag = 7'd1;
      tick();
      mem_ack = 1'b0;
      n_checks++; if (resp_valid !== 2'b01 || resp_tag !== 7'd1 || resp_err !== 1'b0) begin n_errors++; $display("FAIL wr_resp: got valid %b tag %0d err %b exp 01 1 0", resp_valid, resp_tag, resp_err); end
      n_checks++; if (err_spurious !== 1'b0) begin n_errors++; $display("FAIL wr_no_spurious: got %b exp 0", err_spurious); end
      tick();
      n_checks++; if (resp_valid !== 2'b00) begin n_errors++; $display("FAIL wr_resp_pulse: got %b exp 00", resp_valid); end
   endtask

   task automatic test_readback();
      logic [DW-1:0]   rd;
      logic [DW-1:0]   wd;
      logic [GW_D-1:0] exp_g;
      wd = mk_data(32'h1111_1111);
      set_req(0, 1'b1, 4'b0101, 4'b0000, 7'd2, 32'h04, 32'h0);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      n_checks++; if (mem_rd_en !== 4'b0101 || mem_wr_en !== 4'b0000) begin n_errors++; $display("FAIL rd_issue_en: got rd %b wr %b exp 0101 0000", mem_rd_en, mem_wr_en); end
      build_read(rd);
      tick();
      mem_ack = 1'b1;
      mem_output_tag = 7'd2;
      mem_rd_data = rd;
      tick();
      mem_ack = 1'b0;
      mem_rd_data = '0;
      n_checks++; if (resp_valid !== 2'b01 || resp_tag !== 7'd2) begin n_errors++; $display("FAIL rd_resp: got valid %b tag %0d exp 01 2", resp_valid, resp_tag); end
      for (int g = 0; g < 4; g++) begin
         exp_g = (g == 0 || g == 2) ? wd[g*GW_D +: GW_D] : '0;
         n_checks++;
         if (resp_rd_data[g*GW_D +: GW_D] !== exp_g) begin
            n_errors++;
            $display("FAIL rd_data_grp%0d: got low %h exp low %h", g, resp_rd_data[g*GW_D +: 64], exp_g[63:0]);
         end
      end
      tick();
   endtask

   task automatic test_no_access();
      set_req(1, 1'b0, 4'b0000, 4'b0000, 7'd9, 32'h500, 32'h66);
      req_valid = 2'b10;
      #1;
      n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL noacc_grant: got %b exp 10", req_ready); end
      tick();
      req_valid = 2'b00;
      n_checks++; if (resp_valid !== 2'b10 || resp_tag !== 7'd9 || resp_err !== 1'b0) begin n_errors++; $display("FAIL noacc_resp: got valid %b tag %0d err %b exp 10 9 0", resp_valid, resp_tag, resp_err); end
      n_checks++; if (resp_rd_data !== '0 || mem_rd_en !== 4'b0 || mem_wr_en !== 4'b0) begin n_errors++; $display("FAIL noacc_quiet: got data low %h rd %b wr %b exp 0", resp_rd_data[63:0], mem_rd_en, mem_wr_en); end
      tick();
   endtask

   task automatic test_spurious();
      logic [DW-1:0] rd;
      logic [DW-1:0] wd;
      wd = mk_data(32'h1111_1111);
      mem_ack = 1'b1;
      mem_output_tag = 7'd0;
      tick();
      mem_ack = 1'b0;
      n_checks++; if (err_spurious !== 1'b1 || resp_valid !== 2'b00) begin n_errors++; $display("FAIL idle_ack: got spur %b valid %b exp 1 00", err_spurious, resp_valid); end
      tick();
      n_checks++; if (err_spurious !== 1'b0) begin n_errors++; $display("FAIL idle_ack_pulse: got %b exp 0", err_spurious); end
      set_req(0, 1'b1, 4'b0001, 4'b0000, 7'd3, 32'h04, 32'h0);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      build_read(rd);
      tick();
      mem_ack = 1'b1;
      mem_output_tag = 7'd5;
      tick();
      mem_ack = 1'b0;
      n_checks++; if (err_spurious !== 1'b1 || resp_valid !== 2'b00) begin n_errors++; $display("FAIL tag_mismatch: got spur %b valid %b exp 1 00", err_spurious, resp_valid); end
      tick();
      n_checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin n_errors++; $display("FAIL mismatch_stays_wait: got valid %b ready %b exp 00 00", resp_valid, req_ready); end
      mem_ack = 1'b1;
      mem_output_tag = 7'd3;
      mem_rd_data = rd;
      tick();
      mem_ack = 1'b0;
      mem_rd_data = '0;
      n_checks++; if (resp_valid !== 2'b01 || resp_tag !== 7'd3 || err_spurious !== 1'b0) begin n_errors++; $display("FAIL late_match: got valid %b tag %0d spur %b exp 01 3 0", resp_valid, resp_tag, err_spurious); end
      n_checks++; if (resp_rd_data[0 +: GW_D] !== wd[0 +: GW_D]) begin n_errors++; $display("FAIL late_match_data: got low %h exp low %h", resp_rd_data[63:0], wd[63:0]); end
      tick();
   endtask

   task automatic test_timeout();
      int n;
      set_req(1, 1'b1, 4'b0000, 4'b1000, 7'd6, 32'h300, 32'h44);
      req_valid = 2'b10;
      #1;
      n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL to_grant: got %b exp 10", req_ready); end
      tick();
      req_valid = 2'b00;
      n_checks++; if (mem_wr_en !== 4'b1000) begin n_errors++; $display("FAIL to_issue: got %b exp 1000", mem_wr_en); end
      n = 0;
      while (n < 400) begin
         tick();
         n++;
         if (resp_valid !== 2'b00) break;
      end
      n_checks++; if (n != TO + 2) begin n_errors++; $display("FAIL to_latency: got %0d cycles exp %0d", n, TO + 2); end
      n_checks++; if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_tag !== 7'd6) begin n_errors++; $display("FAIL to_resp: got valid %b err %b tag %0d exp 10 1 6", resp_valid, resp_err, resp_tag); end
      n_checks++; if (resp_rd_data !== '0) begin n_errors++; $display("FAIL to_data_zero: got low %h exp 0", resp_rd_data[63:0]); end
      tick();
      n_checks++; if (resp_valid !== 2'b00) begin n_errors++; $display("FAIL to_pulse: got %b exp 00", resp_valid); end
   endtask

   task automatic test_reset_mid_wait();
      set_req(0, 1'b1, 4'b0000, 4'b1111, 7'd4, 32'h400, 32'h55);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (mem_wr_en !== 4'b0 || mem_input_tag !== 7'd0 || mem_gm_or_lds !== 1'b0) begin n_errors++; $display("FAIL mrst_mem: got wr %b tag %0d gm %b exp 0", mem_wr_en, mem_input_tag, mem_gm_or_lds); end
      n_checks++; if (mem_addresses !== '0) begin n_errors++; $display("FAIL mrst_addr: got low %h exp 0", mem_addresses[63:0]); end
      n_checks++; if (resp_valid !== 2'b00 || resp_err !== 1'b0 || err_spurious !== 1'b0) begin n_errors++; $display("FAIL mrst_resp: got valid %b err %b spur %b exp 0", resp_valid, resp_err, err_spurious); end
      mem_ack = 1'b1;
      mem_output_tag = 7'd4;
      tick();
      mem_ack = 1'b0;
      n_checks++; if (err_spurious !== 1'b1 || resp_valid !== 2'b00) begin n_errors++; $display("FAIL mrst_late_ack: got spur %b valid %b exp 1 00", err_spurious, resp_valid); end
      set_req(0, 1'b1, 4'b0001, 4'b0000, 7'd12, 32'h04, 32'h0);
      set_req(1, 1'b1, 4'b0000, 4'b0001, 7'd13, 32'h600, 32'h77);
      req_valid = 2'b11;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL mrst_ptr_zero: got %b exp 01", req_ready); end
      tick();
      req_valid = 2'b00;
      n_checks++; if (mem_input_tag !== 7'd12) begin n_errors++; $display("FAIL mrst_issue_tag: got %0d exp 12", mem_input_tag); end
      tick();
      mem_ack = 1'b1;
      mem_output_tag = 7'd12;
      tick();
      mem_ack = 1'b0;
      n_checks++; if (resp_valid !== 2'b01 || resp_tag !== 7'd12 || resp_err !== 1'b0) begin n_errors++; $display("FAIL mrst_next_req: got valid %b tag %0d err %b exp 01 12 0", resp_valid, resp_tag, resp_err); end
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      req_valid      = '0;
      req_gm_or_lds  = '0;
      req_rd_en      = '0;
      req_wr_en      = '0;
      req_addresses  = '0;
      req_wr_data    = '0;
      req_tag        = '0;
      mem_ack        = 1'b0;
      mem_output_tag = '0;
      mem_rd_data    = '0;

      test_reset();
      test_contention();
      test_write();
      test_readback();
      test_no_access();
      test_spurious();
      test_timeout();
      test_reset_mid_wait();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
